// File: rtl/wishbone_master_if_pkg.sv
// ---------------------------------------------------------------------------
// wishbone_master_if_pkg
// Shared definitions for the CPU-side Wishbone initiator:
//   - bus widths and the zero word
//   - FSM state encoding (IDLE / BUSY / DONE, 2 bits)
//   - packed request payload registered onto the bus
//   - helper selecting what a completed transfer returns to the CPU
// ---------------------------------------------------------------------------
package wishbone_master_if_pkg;

  localparam int unsigned REG_BUS_W = 32;
  localparam int unsigned SEL_W     = 4;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  // Bus master FSM states.
  typedef enum logic [1:0] {
    WB_IDLE = 2'b00,
    WB_BUSY = 2'b01,
    WB_DONE = 2'b10
  } wb_state_e;

  // Request payload held stable on the bus for the whole cycle.
  typedef struct packed {
    logic [REG_BUS_W-1:0] addr;
    logic [REG_BUS_W-1:0] data;
    logic                 we;
    logic [SEL_W-1:0]     sel;
  } wb_req_t;

  localparam wb_req_t WB_REQ_RESET = '0;

  // Writes return nothing to the pipeline; reads return the slave data.
  function automatic logic [REG_BUS_W-1:0] read_capture(
    input logic                 we,
    input logic [REG_BUS_W-1:0] dat
  );
    return we ? ZERO_WORD : dat;
  endfunction

endpackage : wishbone_master_if_pkg

// File: rtl/wishbone_master_if_if.sv
// ---------------------------------------------------------------------------
// wishbone_master_if_if
// Classic Wishbone bus bundle between the CPU initiator and a slave.
//   wishbone_addr_o  32  bus address          (master -> slave)
//   wishbone_data_o  32  bus write data       (master -> slave)
//   wishbone_we_o     1  write enable         (master -> slave)
//   wishbone_sel_o    4  byte selects         (master -> slave)
//   wishbone_stb_o    1  strobe               (master -> slave)
//   wishbone_cyc_o    1  cycle                (master -> slave)
//   wishbone_data_i  32  read data            (slave -> master)
//   wishbone_ack_i    1  acknowledge          (slave -> master)
// Signal names are seen from the master side.
// ---------------------------------------------------------------------------
interface wishbone_master_if_if;
  import wishbone_master_if_pkg::*;

  logic [REG_BUS_W-1:0] wishbone_addr_o;
  logic [REG_BUS_W-1:0] wishbone_data_o;
  logic                 wishbone_we_o;
  logic [SEL_W-1:0]     wishbone_sel_o;
  logic                 wishbone_stb_o;
  logic                 wishbone_cyc_o;
  logic [REG_BUS_W-1:0] wishbone_data_i;
  logic                 wishbone_ack_i;

  modport master (
    output wishbone_addr_o,
    output wishbone_data_o,
    output wishbone_we_o,
    output wishbone_sel_o,
    output wishbone_stb_o,
    output wishbone_cyc_o,
    input  wishbone_data_i,
    input  wishbone_ack_i
  );

  modport slave (
    input  wishbone_addr_o,
    input  wishbone_data_o,
    input  wishbone_we_o,
    input  wishbone_sel_o,
    input  wishbone_stb_o,
    input  wishbone_cyc_o,
    output wishbone_data_i,
    output wishbone_ack_i
  );

endinterface : wishbone_master_if_if

// File: rtl/wishbone_master_if.sv
// ---------------------------------------------------------------------------
// wishbone_master_if
// Initiator end of the CPU Wishbone bus. Turns one pipeline memory request
// into a single classic Wishbone cycle, stalls the pipeline until the cycle
// ends, then holds the read data until the consuming stage takes it.
// Flushes never abort a running cycle; a timeout bounds slaves that never ack.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   cpu_ce_i      request valid
//   cpu_addr_i    byte address
//   cpu_data_i    write data
//   cpu_we_i      1 = write
//   cpu_sel_i     byte lanes
//   stall_i       consuming stage held this cycle
//   flush_i       pipeline flush
//   cpu_data_o    read data to the CPU (valid in DONE, else 0)
//   stallreq_o    stall request (combinational)
//   err_o         one-cycle pulse after a timeout
//   wb            Wishbone master modport
// ---------------------------------------------------------------------------
module wishbone_master_if
  import wishbone_master_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 cpu_ce_i,
  input  logic [REG_BUS_W-1:0] cpu_addr_i,
  input  logic [REG_BUS_W-1:0] cpu_data_i,
  input  logic                 cpu_we_i,
  input  logic [SEL_W-1:0]     cpu_sel_i,
  input  logic                 stall_i,
  input  logic                 flush_i,

  output logic [REG_BUS_W-1:0] cpu_data_o,
  output logic                 stallreq_o,
  output logic                 err_o,

  wishbone_master_if_if.master wb
);

  // A zero TIMEOUT_CYCLES disables the abort; the counter then just saturates.
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b1}};

  wb_state_e            state_q,   state_d;
  wb_req_t              req_q,     req_d;
  logic                 stb_q,     stb_d;
  logic                 cyc_q,     cyc_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 flushed_q, flushed_d;
  logic [REG_BUS_W-1:0] rd_buf_q,  rd_buf_d;
  logic                 err_q,     err_d;

  logic                 start_c;
  logic                 timeout_c;
  logic                 flush_seen_c;

  assign start_c      = cpu_ce_i & ~flush_i;
  assign timeout_c    = TO_EN && (cnt_q == CNT_LAST);
  // A flush arriving on the completing edge still discards the result.
  assign flush_seen_c = flushed_q | flush_i;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      req_q     <= WB_REQ_RESET;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      rd_buf_q  <= ZERO_WORD;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      stb_q     <= stb_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      rd_buf_q  <= rd_buf_d;
      err_q     <= err_d;
    end
  end

  // Next-state, datapath updates and pipeline-side outputs.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    rd_buf_d   = rd_buf_q;
    err_d      = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;

    case (state_q)
      WB_IDLE: begin
        // Acks arriving here are stale (late or after reset) and are dropped.
        stallreq_o = start_c;
        if (start_c) begin
          req_d.addr = cpu_addr_i;
          req_d.data = cpu_data_i;
          req_d.we   = cpu_we_i;
          req_d.sel  = cpu_sel_i;
          stb_d      = 1'b1;
          cyc_d      = 1'b1;
          cnt_d      = '0;
          flushed_d  = 1'b0;
          state_d    = WB_BUSY;
        end
      end

      WB_BUSY: begin
        stallreq_o = 1'b1;
        flushed_d  = flush_seen_c;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (wb.wishbone_ack_i) begin
          // Ack beats a simultaneous timeout.
          rd_buf_d  = read_capture(req_q.we, wb.wishbone_data_i);
          stb_d     = 1'b0;
          cyc_d     = 1'b0;
          req_d.we  = 1'b0;
          req_d.sel = '0;
          state_d   = flush_seen_c ? WB_IDLE : WB_DONE;
        end else if (timeout_c) begin
          rd_buf_d  = ZERO_WORD;
          stb_d     = 1'b0;
          cyc_d     = 1'b0;
          req_d.we  = 1'b0;
          req_d.sel = '0;
          err_d     = 1'b1;
          state_d   = flush_seen_c ? WB_IDLE : WB_DONE;
        end
      end

      WB_DONE: begin
        // Result stays visible until consumed; no new request starts here.
        cpu_data_o = rd_buf_q;
        if (!stall_i || flush_i) begin
          state_d = WB_IDLE;
        end
      end

      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  assign err_o              = err_q;
  assign wb.wishbone_addr_o = req_q.addr;
  assign wb.wishbone_data_o = req_q.data;
  assign wb.wishbone_we_o   = req_q.we;
  assign wb.wishbone_sel_o  = req_q.sel;
  assign wb.wishbone_stb_o  = stb_q;
  assign wb.wishbone_cyc_o  = cyc_q;

endmodule : wishbone_master_if

// File: tb/tb_wishbone_master_if.sv
// ---------------------------------------------------------------------------
// tb_wishbone_master_if
// Directed bench for wishbone_master_if with a hand-driven slave.
// Inputs change 2 time units after the rising edge; outputs are sampled one
// unit later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_wishbone_master_if;
  import wishbone_master_if_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  wishbone_master_if_if wb_bus();

  wishbone_master_if #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o),
    .err_o     (err_o),
    .wb        (wb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
    cpu_ce_i   = 1'b1;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_we_i   = we;
    cpu_sel_i  = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0;
    stall_i = 1'b0; flush_i = 1'b0;
    wb_bus.wishbone_ack_i = 1'b0; wb_bus.wishbone_data_i = '0;
    #3;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", wb_bus.wishbone_stb_o); end
    checks++; if (wb_bus.wishbone_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", wb_bus.wishbone_cyc_o); end
    checks++; if (wb_bus.wishbone_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", wb_bus.wishbone_addr_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_data_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b expected 0", stallreq_o); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    int stb_hi = 0;
    stall_i = 1'b0;
    req(32'h0000_0100, 32'h0, 1'b0, 4'hF);
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL read_stallreq_idle: got %b expected 1", stallreq_o); end
    step();
    cpu_ce_i = 1'b0;
    #1;
    checks++; if (wb_bus.wishbone_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL read_addr: got %h expected 00000100", wb_bus.wishbone_addr_o); end
    checks++; if (wb_bus.wishbone_sel_o !== 4'hF) begin errors++; $display("FAIL read_sel: got %h expected f", wb_bus.wishbone_sel_o); end
    checks++; if (wb_bus.wishbone_we_o !== 1'b0) begin errors++; $display("FAIL read_we: got %b expected 0", wb_bus.wishbone_we_o); end
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        wb_bus.wishbone_ack_i = 1'b1;
        wb_bus.wishbone_data_i = 32'hDEAD_BEEF;
      end
      #1;
      if (wb_bus.wishbone_stb_o === 1'b1 && wb_bus.wishbone_cyc_o === 1'b1) stb_hi++;
      checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL read_stallreq_busy%0d: got %b expected 1", c, stallreq_o); end
      step();
    end
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    #1;
    checks++; if (stb_hi !== 3) begin errors++; $display("FAIL read_stb_cycles: got %0d expected 3", stb_hi); end
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL read_stb_done: got %b expected 0", wb_bus.wishbone_stb_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL read_stallreq_done: got %b expected 0", stallreq_o); end
    checks++; if (cpu_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data_done: got %h expected deadbeef", cpu_data_o); end
    step();
    #1;
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL read_data_idle: got %h expected 0", cpu_data_o); end
  endtask

  task automatic test_partial_write();
    stall_i = 1'b0;
    req(32'h0040_0004, 32'h0000_00AB, 1'b1, 4'b0001);
    step();
    cpu_ce_i = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (c == 2) begin
        wb_bus.wishbone_ack_i = 1'b1;
        wb_bus.wishbone_data_i = 32'h1234_5678;
      end
      #1;
      checks++; if (wb_bus.wishbone_we_o !== 1'b1) begin errors++; $display("FAIL wr_we%0d: got %b expected 1", c, wb_bus.wishbone_we_o); end
      checks++; if (wb_bus.wishbone_sel_o !== 4'b0001) begin errors++; $display("FAIL wr_sel%0d: got %b expected 0001", c, wb_bus.wishbone_sel_o); end
      checks++; if (wb_bus.wishbone_data_o !== 32'h0000_00AB) begin errors++; $display("FAIL wr_data%0d: got %h expected 000000ab", c, wb_bus.wishbone_data_o); end
      checks++; if (wb_bus.wishbone_addr_o !== 32'h0040_0004) begin errors++; $display("FAIL wr_addr%0d: got %h expected 00400004", c, wb_bus.wishbone_addr_o); end
      step();
    end
    wb_bus.wishbone_ack_i = 1'b0;
    #1;
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL wr_cpu_data: got %h expected 0", cpu_data_o); end
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL wr_stb_done: got %b expected 0", wb_bus.wishbone_stb_o); end
    step();
  endtask

  task automatic test_held_result();
    stall_i = 1'b1;
    req(32'h0000_0200, 32'h0, 1'b0, 4'hF);
    step();
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'hCAFE_F00D;
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    // cpu_ce_i stays high: DONE must not launch it.
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (cpu_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL held_data%0d: got %h expected cafef00d", c, cpu_data_o); end
      checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL held_stb%0d: got %b expected 0", c, wb_bus.wishbone_stb_o); end
      checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL held_stallreq%0d: got %b expected 0", c, stallreq_o); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    stall_i = 1'b0;
    req(32'h0000_0204, 32'h0, 1'b0, 4'hF);
    #1;
    checks++; if (cpu_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_done_data: got %h expected cafef00d", cpu_data_o); end
    step();
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 0", wb_bus.wishbone_stb_o); end
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL b2b_stallreq: got %b expected 1", stallreq_o); end
    step();
    cpu_ce_i = 1'b0;
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b1) begin errors++; $display("FAIL b2b_stb: got %b expected 1", wb_bus.wishbone_stb_o); end
    checks++; if (wb_bus.wishbone_addr_o !== 32'h0000_0204) begin errors++; $display("FAIL b2b_addr: got %h expected 00000204", wb_bus.wishbone_addr_o); end
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'h1111_2222;
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    #1;
    checks++; if (cpu_data_o !== 32'h1111_2222) begin errors++; $display("FAIL b2b_data: got %h expected 11112222", cpu_data_o); end
    step();
  endtask

  task automatic test_flush();
    stall_i = 1'b1;
    flush_i = 1'b1;
    req(32'h0000_0300, 32'h0, 1'b0, 4'hF);
    #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stallreq: got %b expected 0", stallreq_o); end
    step();
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL flush_idle_nostart: got %b expected 0", wb_bus.wishbone_stb_o); end
    flush_i = 1'b0;
    step();
    cpu_ce_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b1) begin errors++; $display("FAIL flush_stb_held: got %b expected 1", wb_bus.wishbone_stb_o); end
    step();
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'h55AA_55AA;
    #1;
    checks++; if (wb_bus.wishbone_cyc_o !== 1'b1) begin errors++; $display("FAIL flush_cyc_held: got %b expected 1", wb_bus.wishbone_cyc_o); end
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    #1;
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL flush_no_data: got %h expected 0", cpu_data_o); end
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL flush_stb_end: got %b expected 0", wb_bus.wishbone_stb_o); end
    // In IDLE a fresh request raises stallreq; DONE would not.
    req(32'h0000_0304, 32'h0, 1'b0, 4'hF);
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_back_in_idle: got %b expected 1", stallreq_o); end
    cpu_ce_i = 1'b0;
    stall_i = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    stall_i = 1'b0;
    req(32'h0000_0400, 32'h0, 1'b0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (wb_bus.wishbone_stb_o !== 1'b1) begin errors++; $display("FAIL to_stb%0d: got %b expected 1", c, wb_bus.wishbone_stb_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_err_early%0d: got %b expected 0", c, err_o); end
      step();
    end
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL to_stb_drop: got %b expected 0", wb_bus.wishbone_stb_o); end
    checks++; if (wb_bus.wishbone_cyc_o !== 1'b0) begin errors++; $display("FAIL to_cyc_drop: got %b expected 0", wb_bus.wishbone_cyc_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b expected 1", err_o); end
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL to_cpu_data: got %h expected 0", cpu_data_o); end
    step();
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_err_single: got %b expected 0", err_o); end
    step();
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'h9999_9999;
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL to_late_ack_stb: got %b expected 0", wb_bus.wishbone_stb_o); end
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL to_late_ack_data: got %h expected 0", cpu_data_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_late_ack_err: got %b expected 0", err_o); end
    step();
  endtask

  task automatic test_ack_at_timeout();
    stall_i = 1'b0;
    req(32'h0000_0500, 32'h0, 1'b0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    step();
    step();
    step();
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'h0BAD_F00D;
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ackto_err: got %b expected 0", err_o); end
    checks++; if (cpu_data_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL ackto_data: got %h expected 0badf00d", cpu_data_o); end
    step();
  endtask

  task automatic test_reset_mid_cycle();
    stall_i = 1'b0;
    req(32'h0000_0600, 32'h0, 1'b0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy_stb: got %b expected 1", wb_bus.wishbone_stb_o); end
    rst = 1'b1;
    #1;
    checks++; if (wb_bus.wishbone_stb_o !== 1'b0) begin errors++; $display("FAIL rstmid_stb: got %b expected 0", wb_bus.wishbone_stb_o); end
    checks++; if (wb_bus.wishbone_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got %b expected 0", wb_bus.wishbone_cyc_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rstmid_stallreq: got %b expected 0", stallreq_o); end
    step();
    rst = 1'b0;
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'hFFFF_FFFF;
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    #1;
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL rstmid_stale_ack: got %h expected 0", cpu_data_o); end
    req(32'h0000_0700, 32'h0, 1'b0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    step();
    wb_bus.wishbone_ack_i = 1'b1;
    wb_bus.wishbone_data_i = 32'h1357_2468;
    step();
    wb_bus.wishbone_ack_i = 1'b0;
    wb_bus.wishbone_data_i = 32'h0;
    #1;
    checks++; if (cpu_data_o !== 32'h1357_2468) begin errors++; $display("FAIL rstmid_fresh_read: got %h expected 13572468", cpu_data_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_partial_write();
    test_held_result();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wishbone_master_if
